aes256_round_ctrl: RTL
======================

# aes256_round_ctrl

Sequencer for the iterative AES-256 encryption datapath. It accepts a start request, steps the shared round hardware through the initial AddRoundKey, 13 full rounds and the final round, and drives the 4-bit round address that steers the state demux. For rounds below 14 the address routes state back into the loop; at 14 it routes state to the output. The block paces each round on the key-expansion handshake and holds the ciphertext until the consumer accepts it.

## Interface
- `NROUNDS`, 14: total rounds after the initial AddRoundKey; the final round has no MixColumns.
- `ADDR_W`, 4: round address width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request to encrypt the plaintext currently presented. Sampled only in IDLE.
- `key_valid` input 1: the round key for `round_addr` is available this cycle.
- `out_ready` input 1: the consumer accepts the ciphertext.
- `busy` output 1: high in every state except IDLE.
- `round_addr` output ADDR_W: current round index, 0..14. Drives the demux address and the key-expansion index.
- `key_req` output 1: requests the round key for `round_addr`.
- `load_sel` output 1: selects the plaintext (rather than the loop state) as the datapath input.
- `round_en` output 1: the state register captures the result of a full round.
- `final_en` output 1: the output register captures the result of the final round.
- `out_valid` output 1: ciphertext is valid and held stable.
- `done` output 1: one-cycle pulse on the output handshake.

## Operation
States: IDLE, LOAD, ROUND, FINAL, HOLD.

- **IDLE**
  - All outputs are 0; `round_addr` = 0.
  - If `start` = 1, go to LOAD.
- **LOAD**
  - `round_addr` = 0, `load_sel` = 1, `key_req` = 1.
  - When `key_valid` = 1: `round_en` = 1 (plaintext XOR key0 is captured), `round_addr` becomes 1, go to ROUND.
  - When `key_valid` = 0: stay in LOAD. No enable is asserted.
- **ROUND**
  - `key_req` = 1.
  - When `key_valid` = 1: `round_en` = 1 and `round_addr` increments.
  - At `round_addr` = NROUNDS-1 (13) with `key_valid`: `round_addr` becomes 14, go to FINAL.
- **FINAL**
  - `round_addr` = 14, `key_req` = 1.
  - When `key_valid` = 1: `final_en` = 1, go to HOLD.
- **HOLD**
  - `round_addr` stays at 14, `out_valid` = 1.
  - When `out_ready` = 1: `done` = 1 in the same cycle, `round_addr` becomes 0, go to IDLE.

Rules:
- `round_en` and `final_en` are mutually exclusive and are never asserted without `key_valid`.
- `key_valid` stalls freeze `round_addr` and the state.
- `round_addr` never exceeds 14 and never wraps. It returns to 0 only via HOLD to IDLE or via reset.
- `start` is ignored outside IDLE; there is no queuing.
- All outputs decode combinationally from the state, `round_addr` and the current inputs. The state and `round_addr` are registered.

## Timing
- **Reset:** state = IDLE, `round_addr` = 0, and every output = 0, asynchronously. Asserting `rst` mid-encryption aborts it: no `done` and no `out_valid` are produced.
- **Latency with `key_valid` held high:**
  - `start` sampled at cycle 0.
  - LOAD at cycle 1.
  - ROUND at cycles 2-14.
  - FINAL at cycle 15.
  - `out_valid` first high at cycle 16.
- **Each `key_valid` = 0 cycle** adds exactly one cycle.
- **Back-to-back operation:** a `start` in the cycle after `done` is accepted. The minimum period is therefore 17 cycles plus output stall cycles.
- **`out_valid` hold:** `out_valid` stays high until it is sampled together with `out_ready`. `out_ready` without `out_valid` has no effect.

## Structure
- Shared package `aes256_pkg` holds:
  - `N` = 16 (state bytes);
  - `NROUNDS` = 14;
  - `ADDR_W` = 4;
  - the `ctrl_state_t` enum (IDLE, LOAD, ROUND, FINAL, HOLD).
- The demux and datapath use the same package constants.
- Single module, no sub-module. The FSM and round counter are one always_ff block with the asynchronous reset; output decode is one always_comb block.

## Test plan
1. **Nominal run:** reset, `key_valid` = 1, `out_ready` = 1, pulse `start`. Check:
   - `round_addr` sequence 0, 1, …, 14;
   - 14 `round_en` pulses, then 1 `final_en`;
   - `out_valid` and `done` at cycle 16;
   - IDLE at cycle 17.
2. **Key stall:** drop `key_valid` for 3 cycles at `round_addr` = 5. Check:
   - `round_addr` holds at 5;
   - no enables during the stall;
   - `out_valid` at cycle 19.
3. **Output backpressure:** `out_ready` = 0 for 4 cycles. Check:
   - `out_valid` is held and `round_addr` stays at 14;
   - `done` fires only in the cycle `out_ready` rises.
4. **Ignored start:** pulse `start` while in ROUND at `round_addr` = 7. Check that there is no restart and the sequence completes normally.
5. **Reset mid-run:** assert `rst` at `round_addr` = 9. Check:
   - all outputs are 0 immediately and `round_addr` = 0;
   - there is no `done` afterwards;
   - a new `start` gives the nominal 16-cycle latency.
6. **Back-to-back:** `start` high continuously. Check that `done` pulses are spaced exactly 17 cycles apart.

Source files
------------

// File: rtl/aes256_pkg.sv
// aes256_pkg: constants and types shared by the AES-256 round controller,
// the state demux and the round datapath.
//   N          - state width in bytes
//   NROUNDS    - rounds after the initial AddRoundKey (last one skips MixColumns)
//   ADDR_W     - round address width
//   ctrl_state_t - round controller states
package aes256_pkg;

   localparam int unsigned N       = 16;
   localparam int unsigned NROUNDS = 14;
   localparam int unsigned ADDR_W  = 4;

   // Address of the final round, and of the last full round before it
   localparam logic [ADDR_W-1:0] ADDR_FINAL = ADDR_W'(NROUNDS);
   localparam logic [ADDR_W-1:0] ADDR_LAST_FULL = ADDR_W'(NROUNDS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      HOLD  = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/aes256_round_ctrl.sv
// aes256_round_ctrl: sequences the shared AES-256 round hardware through the
// initial AddRoundKey, 13 full rounds and the final round, pacing each step on
// the key-expansion handshake and holding the ciphertext until accepted.
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   start            - begin encryption (sampled only in IDLE)
//   key_valid        - round key for round_addr is available this cycle
//   out_ready        - consumer accepts the ciphertext
//   busy             - controller is not IDLE
//   round_addr       - current round index 0..14 (demux + key index)
//   key_req          - request round key for round_addr
//   load_sel         - select plaintext as datapath input
//   round_en         - capture a full-round result into the state register
//   final_en         - capture the final-round result into the output register
//   out_valid        - ciphertext valid and held
//   done             - one-cycle pulse on the output handshake
// Outputs decode combinationally from the registered state/round_addr and the
// current inputs.
module aes256_round_ctrl
   import aes256_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              key_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [ADDR_W-1:0] round_addr,
   output logic              key_req,
   output logic              load_sel,
   output logic              round_en,
   output logic              final_en,
   output logic              out_valid,
   output logic              done
);

   ctrl_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // State and round counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Next state, round counter advance and output decode
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      key_req   = 1'b0;
      load_sel  = 1'b0;
      round_en  = 1'b0;
      final_en  = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         IDLE: begin
            addr_d = '0;
            if (start) state_d = LOAD;
         end
         LOAD: begin
            key_req  = 1'b1;
            load_sel = 1'b1;
            if (key_valid) begin
               round_en = 1'b1;
               addr_d   = ADDR_W'(1);
               state_d  = ROUND;
            end
         end
         ROUND: begin
            key_req = 1'b1;
            if (key_valid) begin
               round_en = 1'b1;
               // Leaving the last full round lands exactly on the final address
               if (addr_q == ADDR_LAST_FULL) begin
                  addr_d  = ADDR_FINAL;
                  state_d = FINAL;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         FINAL: begin
            key_req = 1'b1;
            if (key_valid) begin
               final_en = 1'b1;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               done    = 1'b1;
               addr_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            addr_d  = '0;
         end
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign round_addr = addr_q;

endmodule
